// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the eight requesters and the round-robin arbiter
// that drives the shared 8:1 result selector.
//   master : requester side (drives arb_en, req; observes grant/sel/sel_valid/hold_cnt)
//   slave  : arbiter side   (observes arb_en, req; drives grant/sel/sel_valid/hold_cnt)
interface mux_rr_arbiter_if #(
  parameter int unsigned HOLD_W = 8
);
  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  logic              arb_en;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  grant;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output arb_en, req,
    input  grant, sel, sel_valid, hold_cnt
  );

  modport slave (
    input  arb_en, req,
    output grant, sel, sel_valid, hold_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 8:1 result selector.
// A winner keeps the grant for as long as it holds its request, so bursts are
// never interleaved; every handover passes through one idle (bubble) cycle.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : mux_rr_arbiter_if.slave (arb_en, req in; grant, sel, sel_valid,
//             hold_cnt out, all registered)
// Optional build macro: MUX_ARB_TIMEOUT_EN -- preempt an owner after MAX_HOLD
// cycles when another requester is waiting.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_rr_arbiter_if.slave bus
);
  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  // Reject configurations where the hold counter cannot reach MAX_HOLD.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> HOLD_W) != 0) begin : g_bad_cfg
    $error("mux_rr_arbiter: MAX_HOLD out of range for HOLD_W");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [N_REQ-1:0]  grant_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;
  logic [HOLD_W-1:0] hold_q;

  logic [SEL_W-1:0]  win_idx_c;
  logic              win_found_c;
  logic              preempt_c;
  logic              release_c;

  // First set request bit at or after ptr, wrapping modulo 8.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = ptr;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!win_found_c && bus.req[ptr + SEL_W'(i)]) begin
        win_found_c = 1'b1;
        win_idx_c   = ptr + SEL_W'(i);
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Owner has used its full slot and somebody else is waiting.
  always_comb begin
    preempt_c = bus.req[sel_q] && (hold_q == HOLD_W'(MAX_HOLD))
                && ((bus.req & ~grant_q) != '0);
  end
`else
  always_comb begin
    preempt_c = 1'b0;
  end
`endif

  always_comb begin
    release_c = !bus.req[sel_q] || preempt_c;
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arb_en && win_found_c) begin
            grant_q <= N_REQ'(1) << win_idx_c;
            sel_q   <= win_idx_c;
            valid_q <= 1'b1;
            hold_q  <= HOLD_W'(1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (release_c) begin
            // sel_q is left untouched so the selector code stays stable while idle.
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr     <= sel_q + SEL_W'(1);
            state   <= IDLE;
          end else if (hold_q != '1) begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.hold_cnt  = hold_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_mux_rr_arbiter;
  localparam int unsigned HOLD_W = 8;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned TB_MAX_HOLD = 4;
  localparam bit          TIMEOUT     = 1'b1;
`else
  localparam int unsigned TB_MAX_HOLD = 16;
  localparam bit          TIMEOUT     = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mux_rr_arbiter_if #(.HOLD_W(HOLD_W)) bus ();

  mux_rr_arbiter #(
    .MAX_HOLD(TB_MAX_HOLD),
    .HOLD_W  (HOLD_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: owner index (-1 = nobody), rotating start, hold count.
  int m_owner, m_ptr, m_hold, m_sel;

  task automatic model_step();
    int w;
    logic [7:0] others;
    if (m_owner < 0) begin
      if (bus.arb_en && bus.req != 8'h00) begin
        w = -1;
        for (int k = 0; k < 8; k++)
          if (w < 0 && bus.req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
        m_owner = w;
        m_sel   = w;
        m_hold  = 1;
      end
    end else begin
      others = bus.req & ~(8'h01 << m_owner);
      if (!bus.req[m_owner] ||
          (TIMEOUT && m_hold == int'(TB_MAX_HOLD) && others != 8'h00)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_hold  = 0;
      end else if (m_hold < 255) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_sel   = 0;
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input int eh);
    n_cmp++;
    if (bus.grant !== eg || bus.sel !== es || bus.sel_valid !== ev ||
        bus.hold_cnt !== HOLD_W'(eh)) begin
      n_err++;
      $display("FAIL %s @%0t: got grant=%h sel=%0d valid=%b hold=%0d, want grant=%h sel=%0d valid=%b hold=%0d",
               name, $time, bus.grant, bus.sel, bus.sel_valid, bus.hold_cnt, eg, es, ev, eh);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req    = 8'h00;
    bus.arb_en = 1'b1;
    rst_n      = 1'b0;
    step();
    rst_n = 1'b1;
    check("reset", 8'h00, 3'd0, 1'b0, 0);
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    int         h;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [7:0] exp_g;
    int o;

    tbl[0]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1};
    tbl[1]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 2};
    tbl[2]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 3};
    tbl[3]  = '{1'b1, 8'h09, 8'h00, 3'd2, 1'b0, 0};  // release, ptr=3
    tbl[4]  = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1};  // bit 3 beats bit 0
    tbl[5]  = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 2};
    tbl[6]  = '{1'b1, 8'h01, 8'h00, 3'd3, 1'b0, 0};  // ptr=4
    tbl[7]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1};
    tbl[8]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 2};  // arb_en=0 keeps tenure
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 0};  // ptr=1
    tbl[10] = '{1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 0};  // blocked
    tbl[11] = '{1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 0};
    tbl[12] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1};
    tbl[13] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 2};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 0};  // ptr=5
    tbl[15] = '{1'b1, 8'h00, 8'h00, 3'd4, 1'b0, 0};  // idle, static
    tbl[16] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1};
    tbl[17] = '{1'b1, 8'h00, 8'h00, 3'd6, 1'b0, 0};  // ptr=7
    tbl[18] = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1};  // wrap order 7,0,...
    tbl[19] = '{1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 0};  // ptr=0
    tbl[20] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1};
    tbl[21] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 0};

    rst_n      = 1'b1;
    bus.req    = 8'h00;
    bus.arb_en = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 22; i++) begin
      bus.arb_en = tbl[i].en;
      bus.req    = tbl[i].req;
      step();
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].v, tbl[i].h);
    end

    // All eight requesting: each owner drops after two cycles, order 0..7,0.
    do_reset();
    bus.req = 8'hFF;
    step();
    check("rr_first", 8'h01, 3'd0, 1'b1, 1);
    for (int k = 0; k < 8; k++) begin
      o = k;
      step();
      check($sformatf("rr_hold%0d", k), 8'h01 << o, 3'(o), 1'b1, 2);
      bus.req = 8'hFF & ~(8'h01 << o);
      step();
      check($sformatf("rr_bubble%0d", k), 8'h00, 3'(o), 1'b0, 0);
      bus.req = 8'hFF;
      step();
      exp_g = 8'h01 << ((o + 1) % 8);
      check($sformatf("rr_next%0d", k), exp_g, 3'((o + 1) % 8), 1'b1, 1);
    end

    // Asynchronous reset in the middle of a tenure.
    do_reset();
    bus.req = 8'h20;
    step();
    check("ar_grant", 8'h20, 3'd5, 1'b1, 1);
    step();
    check("ar_hold", 8'h20, 3'd5, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async", 8'h00, 3'd0, 1'b0, 0);
    bus.req = 8'h21;
    #1;
    rst_n = 1'b1;
    step();
    check("ar_after", 8'h01, 3'd0, 1'b1, 1);

`ifdef MUX_ARB_TIMEOUT_EN
    // Two steady requesters alternate every MAX_HOLD cycles with a bubble.
    do_reset();
    bus.req = 8'h03;
    for (int r = 0; r < 4; r++) begin
      for (int h = 1; h <= int'(TB_MAX_HOLD); h++) begin
        step();
        check($sformatf("to_own%0d_%0d", r, h), 8'h01 << (r % 2), 3'(r % 2), 1'b1, h);
      end
      step();
      check($sformatf("to_bubble%0d", r), 8'h00, 3'(r % 2), 1'b0, 0);
    end
    // A lone requester is never preempted.
    do_reset();
    bus.req = 8'h01;
    for (int h = 1; h <= 12; h++) begin
      step();
      check($sformatf("to_alone%0d", h), 8'h01, 3'd0, 1'b1, h);
    end
`endif

    // Randomized traffic against the model, plus structural invariants.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.req    = bus.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      bus.arb_en = ($urandom_range(0, 7) != 0);
      step();
      exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      check($sformatf("rand%0d", c), exp_g, 3'(m_sel), (m_owner >= 0), m_hold);
      n_cmp++;
      if (!$onehot0(bus.grant) || bus.sel_valid !== (|bus.grant)) begin
        n_err++;
        $display("FAIL inv%0d: grant=%h sel_valid=%b, want zero/one-hot grant and sel_valid=|grant",
                 c, bus.grant, bus.sel_valid);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
